sdram_dq_seq: RTL and testbench

SDRAM_DQ_SEQ -- requirements
Module: sdram_dq_seq

---
 rtl/sdram_dq_seq.sv | 92 +++++++++
 tb/tb_sdram_dq_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dq_seq.sv
// SDRAM DQ data-phase sequencer: drives write beats combinationally in the accept cycle and
// captures read beats CL+RD_DELAY cycles later. Backpressure is via cmd_ready, which enforces burst spacing and write-after-read turnaround.
module sdram_dq_seq #(
  parameter int W        = 16,
  parameter int BL       = 4,
  parameter int CL       = 2,
  parameter int RD_DELAY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic         cmd_write,
  output logic         cmd_ready,
  input  logic [W-1:0] wdata,
  output logic         wdata_ready,
  output logic [W-1:0] rdata,
  output logic         rdata_valid,
  output logic [W-1:0] dq_o,
  output logic [W-1:0] dq_oe,
  input  logic [W-1:0] dq_i,
  output logic         busy
);

  localparam int LAT   = CL + RD_DELAY;
  localparam int DEPTH = LAT + BL;
  localparam int CW    = $clog2(CL + BL + 1);
  // Beat k must reach bit 0 at T+LAT+k; the mask is inserted at T+1.
  localparam logic [DEPTH-1:0] RD_MASK = DEPTH'((2 ** BL) - 1) << (LAT - 1);

  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]    ta_cnt_q, ta_cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             rvld_q, rvld_d;

  logic wr_block, wr_ok, rd_ok, wr_acc, rd_acc, wr_active;

  always_comb begin
    wr_block  = (wr_cnt_q != '0);
    rd_ok     = !wr_block && (rd_cnt_q == '0);
    wr_ok     = !wr_block && (ta_cnt_q == '0);
    cmd_ready = !rst && (cmd_write ? wr_ok : rd_ok);
    wr_acc    = cmd_valid && cmd_ready && cmd_write;
    rd_acc    = cmd_valid && cmd_ready && !cmd_write;
    wr_active = !rst && (wr_acc || wr_block);
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    ta_cnt_d = ta_cnt_q;
    if (wr_acc)                wr_cnt_d = CW'(BL - 1);
    else if (wr_cnt_q != '0)   wr_cnt_d = wr_cnt_q - CW'(1);
    if (rd_acc)                rd_cnt_d = CW'(BL - 1);
    else if (rd_cnt_q != '0)   rd_cnt_d = rd_cnt_q - CW'(1);
    // Write is held off until the last read beat has left the pad plus one turnaround cycle.
    if (rd_acc)                ta_cnt_d = CW'(CL + BL);
    else if (ta_cnt_q != '0)   ta_cnt_d = ta_cnt_q - CW'(1);
    vld_d   = (vld_q >> 1) | (rd_acc ? RD_MASK : '0);
    rvld_d  = vld_q[0];
    rdata_d = vld_q[0] ? dq_i : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      ta_cnt_q <= '0;
      vld_q    <= '0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      ta_cnt_q <= ta_cnt_d;
      vld_q    <= vld_d;
      rdata_q  <= rdata_d;
      rvld_q   <= rvld_d;
    end
  end

  always_comb begin
    wdata_ready = wr_active;
    dq_oe       = {W{wr_active}};
    dq_o        = wr_active ? wdata : '0;
    rdata_valid = !rst && rvld_q;
    rdata       = rst ? '0 : rdata_q;
    busy        = !rst && (wr_block || (vld_q != '0));
  end

endmodule

// File: tb/tb_sdram_dq_seq.sv
// Testbench for sdram_dq_seq: directed scenarios plus a randomized run against a timing model.
module tb_sdram_dq_seq;

  localparam int W = 16, BL = 4, CL = 2, RDD = 2, L = CL + RDD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_write = 1'b0;
  logic         cmd_ready, wdata_ready, rdata_valid, busy;
  logic [W-1:0] wdata = '0, dq_i = '0;
  logic [W-1:0] rdata, dq_o, dq_oe;

  int checks = 0, failures = 0;

  sdram_dq_seq #(.W(W), .BL(BL), .CL(CL), .RD_DELAY(RDD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_write(cmd_write),
    .cmd_ready(cmd_ready), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .dq_o(dq_o), .dq_oe(dq_oe),
    .dq_i(dq_i), .busy(busy)
  );

  always #5 clk = ~clk;

  // Timing model: commands are remembered by accept cycle, outputs derived from the timing rules.
  int cyc = 0;
  int last_wr = -1000, last_rd = -1000;
  int rd_t[$];
  logic [W-1:0] dq_hist[int];
  logic e_ready, e_wrdy, e_rv, e_busy, e_acc_w, e_acc_r;
  logic [W-1:0] e_dq_o, e_dq_oe, e_rdata;

  function automatic bit in_win(int c, int s, int n);
    return (c >= s) && (c < s + n);
  endfunction

  task automatic model_eval();
    bit rw, rr, won;
    e_ready = 0; e_wrdy = 0; e_rv = 0; e_busy = 0; e_acc_w = 0; e_acc_r = 0;
    e_dq_o = '0; e_dq_oe = '0; e_rdata = '0;
    if (!rst) begin
      rw = (cyc >= last_wr + BL) && (cyc >= last_rd + CL + BL + 1);
      rr = (cyc >= last_wr + BL) && (cyc >= last_rd + BL);
      e_ready = cmd_write ? rw : rr;
      e_acc_w = cmd_valid && e_ready && cmd_write;
      e_acc_r = cmd_valid && e_ready && !cmd_write;
      won = e_acc_w || in_win(cyc, last_wr + 1, BL - 1);
      e_wrdy  = won;
      e_dq_oe = won ? '1 : '0;
      e_dq_o  = won ? wdata : '0;
      e_busy  = in_win(cyc, last_wr + 1, BL - 1);
      foreach (rd_t[i]) begin
        if (in_win(cyc, rd_t[i] + L + 1, BL)) begin
          e_rv = 1;
          e_rdata = dq_hist[cyc - 1];
        end
        if (in_win(cyc, rd_t[i] + 1, L + BL - 1)) e_busy = 1;
      end
    end
  endtask

  task automatic model_commit();
    dq_hist[cyc] = dq_i;
    if (rst) begin
      rd_t.delete();
      last_wr = -1000;
      last_rd = -1000;
    end else begin
      if (e_acc_w) last_wr = cyc;
      if (e_acc_r) begin
        last_rd = cyc;
        rd_t.push_back(cyc);
      end
    end
    while (rd_t.size() > 0 && rd_t[0] + L + BL + 2 < cyc) void'(rd_t.pop_front());
    cyc++;
  endtask

  task automatic sample();
    #4;
  endtask

  task automatic next();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1; cmd_write = i[0]; wdata = W'($urandom); dq_i = W'($urandom);
      sample();
      checks++;
      if ({cmd_ready, wdata_ready, rdata_valid, busy} !== 4'b0 || rdata !== '0 ||
          dq_oe !== '0 || dq_o !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got rdy=%b wrdy=%b rv=%b busy=%b rdata=%h oe=%h dq_o=%h exp all 0",
                 i, cmd_ready, wdata_ready, rdata_valid, busy, rdata, dq_oe, dq_o);
      end
      next();
    end
    rst = 0; cmd_valid = 0; cmd_write = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_ready_read got=%b exp=1", cmd_ready);
    end
    cmd_write = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_ready_write got=%b exp=1", cmd_ready);
    end
    next();
  endtask

  task automatic test_single_write();
    logic [W-1:0] exp_d;
    for (int rel = 0; rel < 16; rel++) begin
      cmd_valid = (rel == 10); cmd_write = 1;
      exp_d = W'(16'h1111 * (rel - 9));
      wdata = (rel >= 10 && rel <= 13) ? exp_d : W'($urandom);
      dq_i = W'($urandom);
      sample();
      if (rel >= 10 && rel <= 13) begin
        checks++;
        if (dq_oe !== 16'hFFFF || dq_o !== exp_d || wdata_ready !== 1'b1) begin
          failures++;
          $display("FAIL single_write_beat rel=%0d got oe=%h dq_o=%h wrdy=%b exp oe=ffff dq_o=%h wrdy=1",
                   rel, dq_oe, dq_o, wdata_ready, exp_d);
        end
      end
      if (rel == 11) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_write_busy got=%b exp=1", busy); end
      end
      if (rel == 14 || rel == 9) begin
        checks++;
        if (dq_oe !== '0 || dq_o !== '0 || wdata_ready !== 1'b0) begin
          failures++;
          $display("FAIL single_write_idle rel=%0d got oe=%h dq_o=%h wrdy=%b exp 0", rel, dq_oe, dq_o, wdata_ready);
        end
      end
      next();
    end
    cmd_valid = 0;
  endtask

  task automatic test_single_read();
    logic [W-1:0] exp_r;
    for (int rel = 0; rel < 24; rel++) begin
      cmd_valid = (rel == 10); cmd_write = 0; wdata = W'($urandom);
      dq_i = W'(16'hA000 + rel);
      sample();
      exp_r = W'(16'hA000 + rel - 1);
      checks++;
      if (rdata_valid !== (rel >= 15 && rel <= 18)) begin
        failures++;
        $display("FAIL single_read_valid rel=%0d got=%b exp=%b", rel, rdata_valid, (rel >= 15 && rel <= 18));
      end
      if (rel >= 15 && rel <= 18) begin
        checks++;
        if (rdata !== exp_r) begin
          failures++; $display("FAIL single_read_data rel=%0d got=%h exp=%h", rel, rdata, exp_r);
        end
      end
      if (dq_oe !== '0) begin
        checks++; failures++; $display("FAIL single_read_oe rel=%0d got=%h exp=0", rel, dq_oe);
      end
      next();
    end
    cmd_valid = 0;
  endtask

  task automatic test_two_reads();
    int nv = 0;
    for (int rel = 0; rel < 28; rel++) begin
      cmd_valid = (rel == 10 || rel == 14); cmd_write = 0;
      dq_i = W'(16'hB000 + rel);
      sample();
      if (rel == 13) begin
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rar_ready_early got=%b exp=0", cmd_ready); end
      end
      if (rel == 14) begin
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rar_ready_at_bl got=%b exp=1", cmd_ready); end
      end
      if (rdata_valid === 1'b1) nv++;
      checks++;
      if (rdata_valid !== (rel >= 15 && rel <= 22) ||
          (rdata_valid === 1'b1 && rdata !== W'(16'hB000 + rel - 1))) begin
        failures++;
        $display("FAIL two_reads rel=%0d got v=%b d=%h exp v=%b d=%h", rel, rdata_valid, rdata,
                 (rel >= 15 && rel <= 22), W'(16'hB000 + rel - 1));
      end
      next();
    end
    cmd_valid = 0;
    checks++;
    if (nv != 8) begin failures++; $display("FAIL two_reads_count got=%0d exp=8", nv); end
  endtask

  task automatic test_write_after_read();
    for (int rel = 0; rel < 24; rel++) begin
      cmd_valid = (rel >= 10 && rel <= 17); cmd_write = (rel != 10);
      wdata = W'($urandom); dq_i = W'($urandom);
      sample();
      if (rel >= 11 && rel <= 17) begin
        checks++;
        if (cmd_ready !== (rel == 17)) begin
          failures++; $display("FAIL war_ready rel=%0d got=%b exp=%b", rel, cmd_ready, (rel == 17));
        end
      end
      checks++;
      if (dq_oe !== ((rel >= 17 && rel <= 20) ? 16'hFFFF : 16'h0)) begin
        failures++; $display("FAIL war_oe rel=%0d got=%h", rel, dq_oe);
      end
      next();
    end
    cmd_valid = 0;
  endtask

  task automatic test_back_to_back();
    int nb = 0;
    for (int rel = 0; rel < 24; rel++) begin
      cmd_valid = (rel == 10 || rel == 14); cmd_write = 1;
      wdata = W'($urandom); dq_i = W'($urandom);
      sample();
      if (rel == 14) begin
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL waw_ready got=%b exp=1", cmd_ready); end
      end
      if (wdata_ready === 1'b1) nb++;
      checks++;
      if (wdata_ready !== (rel >= 10 && rel <= 17) || (wdata_ready === 1'b1 && dq_o !== wdata)) begin
        failures++;
        $display("FAIL waw_beat rel=%0d got wrdy=%b dq_o=%h exp wrdy=%b dq_o=%h", rel, wdata_ready, dq_o,
                 (rel >= 10 && rel <= 17), wdata);
      end
      next();
    end
    cmd_valid = 0;
    checks++;
    if (nb != 8) begin failures++; $display("FAIL waw_count got=%0d exp=8", nb); end
  endtask

  task automatic test_reset_mid_read();
    int nv = 0;
    for (int rel = 0; rel < 32; rel++) begin
      cmd_valid = (rel == 10); cmd_write = 0; rst = (rel == 12);
      dq_i = W'($urandom);
      if (rel == 13) begin
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
          failures++; $display("FAIL rst_mid_ready_read got rdy=%b busy=%b exp 1 0", cmd_ready, busy);
        end
        cmd_write = 1;
      end
      sample();
      if (rel == 13) begin
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready_write got=%b exp=1", cmd_ready); end
      end
      if (rel == 12) begin
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || rdata !== '0) begin
          failures++; $display("FAIL rst_mid_outputs got rdy=%b busy=%b rdata=%h exp 0", cmd_ready, busy, rdata);
        end
      end
      if (rel >= 12 && rdata_valid === 1'b1) nv++;
      next();
    end
    rst = 0;
    checks++;
    if (nv != 0) begin failures++; $display("FAIL rst_mid_valid_count got=%0d exp=0", nv); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_write = ($urandom_range(0, 2) == 0);
      wdata     = W'($urandom);
      dq_i      = W'($urandom);
      sample();
      model_eval();
      checks++;
      if (cmd_ready !== e_ready || wdata_ready !== e_wrdy || dq_oe !== e_dq_oe || dq_o !== e_dq_o ||
          rdata_valid !== e_rv || busy !== e_busy || (e_rv && rdata !== e_rdata)) begin
        failures++;
        $display("FAIL random cyc=%0d got rdy=%b wrdy=%b oe=%h dq_o=%h rv=%b rd=%h busy=%b exp rdy=%b wrdy=%b oe=%h dq_o=%h rv=%b rd=%h busy=%b",
                 cyc, cmd_ready, wdata_ready, dq_oe, dq_o, rdata_valid, rdata, busy,
                 e_ready, e_wrdy, e_dq_oe, e_dq_o, e_rv, e_rdata, e_busy);
      end
      next();
    end
    rst = 0; cmd_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_two_reads();
    test_write_after_read();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
